db_read_addr_gen: RTL and testbench
===================================

DB_READ_ADDR_GEN -- requirements
Module: db_read_addr_gen

Interface
REQ-001 SHALL provide ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL provide: clk_en  in  1  global clock enable; all state frozen when 0.
REQ-003 SHALL provide: flush  in  1  synchronous abort to IDLE.
REQ-004 SHALL provide: start  in  1  begin a run; sampled in IDLE only.
REQ-005 SHALL provide: dimensionality  in  4  active loop dimensions, 1..3.
REQ-006 SHALL provide: starting_addr  in  16  base word address.
REQ-007 SHALL provide: stride_0/1/2  in  16 each  per-dimension address increments.
REQ-008 SHALL provide: range_0/1/2  in  16 each  per-dimension trip counts.
REQ-009 SHALL provide: iter_cnt  in  16  number of full passes per run.
REQ-010 SHALL provide: addr_out  out  16  read address into active double-buffer bank.
REQ-011 SHALL provide: addr_valid  out  1  addr_out is valid.
REQ-012 SHALL provide: addr_ready  in  1  downstream memory core accepts (ren); transfer = valid & ready & clk_en.
REQ-013 SHALL provide: bank_sel  out  1  read bank; write side uses its inverse.
REQ-014 SHALL provide: pass_done  out  1  one-cycle pulse on the last transfer of each pass.
REQ-015 SHALL provide: done  out  1  one-cycle pulse when the run completes.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 IDLE->RUN SHALL occur on start & clk_en; idx0/idx1/idx2 and pass_cnt SHALL be cleared.
REQ-018 In RUN, addr_valid SHALL be 1 and addr_out = starting_addr + idx0*stride_0 + idx1*stride_1 + idx2*stride_2, truncated mod 2^16.
REQ-019 First address SHALL appear the cycle after start is accepted, with zero additional latency per transfer.
REQ-020 On each transfer, idx0 SHALL increment; at range_0-1 it SHALL wrap to 0 and carry into idx1; idx1 SHALL carry into idx2 likewise.
REQ-021 Dimensions >= dimensionality SHALL be treated as range 1; dimensionality 0 SHALL be treated as 1, and values >3 as 3.
REQ-022 range_x == 0 SHALL be treated as 1; iter_cnt == 0 SHALL be treated as 1.
REQ-023 With addr_valid=1 & addr_ready=0, addr_out and all indices SHALL hold.
REQ-024 On the transfer where all active indices are at their maxima, pass_done SHALL pulse in that cycle, bank_sel SHALL toggle next cycle, and pass_cnt SHALL increment.
REQ-025 When that transfer completes pass iter_cnt, FSM SHALL go to DONE; addr_valid SHALL be 0 in DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 start asserted in RUN or DONE SHALL be ignored.
REQ-028 Configuration inputs SHALL be held constant during RUN; behaviour under a mid-run change is undefined.
REQ-029 flush & clk_en SHALL force IDLE and clear indices and pass_cnt; bank_sel SHALL hold; done and pass_done SHALL not pulse.
REQ-030 clk_en=0 SHALL freeze all state; pass_done and done SHALL be 0 during frozen cycles.
REQ-031 In IDLE, addr_valid SHALL be 0 and addr_out SHALL equal starting_addr.

Reset
REQ-032 reset SHALL override clk_en and flush.
REQ-033 reset SHALL set: state IDLE; indices and pass_cnt 0; bank_sel 0; addr_valid 0; pass_done 0; done 0.
REQ-034 reset asserted mid-run SHALL abort the run; no done pulse SHALL follow.

Verification
REQ-035 Stimulus: dim=3, strides 1/3/9, ranges 3/3/3, start_addr 0, iter_cnt 1, ready=1. Required: addresses 0..26 in order, one per cycle; pass_done with addr 26; done one cycle later; bank_sel=1.
REQ-036 Stimulus: dim=1, stride_0=2, range_0=4, start_addr 5, iter_cnt 2. Required: sequence 5,7,9,11,5,7,9,11; bank_sel toggles 0->1->0; exactly one done pulse.
REQ-037 Stimulus: REQ-035 setup with ready low on cycles 3-5. Required: addr_out holds 3 during the stall; no address skipped or duplicated.
REQ-038 Stimulus: dim=2, stride_0=0xFFFF, stride_1=1, ranges 2/2, start_addr 0. Required: sequence 0x0000,0xFFFF,0x0001,0x0000, showing mod-2^16 wrap.
REQ-039 Stimulus: reset after 10 transfers of REQ-035, then start again. Required: bank_sel=0; no done pulse; sequence restarts at 0.
REQ-040 Stimulus: flush after 5 transfers; clk_en=0 for 4 cycles mid-run. Required: after flush, IDLE with bank_sel unchanged; under clk_en=0, outputs frozen; after re-enable, sequence continues unbroken.

Source files
------------

// File: rtl/db_read_addr_gen_if.sv
// Read-address handshake between db_read_addr_gen and the double-buffered memory core.
// The generator drives the master side; the memory core drives addr_ready on the slave side.
interface db_read_addr_gen_if;
  logic [15:0] addr_out;
  logic        addr_valid;
  logic        addr_ready;
  logic        bank_sel;
  logic        pass_done;
  logic        done;

  modport master (
    output addr_out, addr_valid, bank_sel, pass_done, done,
    input  addr_ready
  );

  modport slave (
    input  addr_out, addr_valid, bank_sel, pass_done, done,
    output addr_ready
  );
endinterface

// File: rtl/db_read_addr_gen.sv
// Up-to-3-deep nested-loop read address generator for a double-buffered memory.
// Each completed pass flips the read bank; the run ends after iter_cnt passes.
module db_read_addr_gen (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               start,
  input  logic [3:0]         dimensionality,
  input  logic [15:0]        starting_addr,
  input  logic [15:0]        stride_0,
  input  logic [15:0]        stride_1,
  input  logic [15:0]        stride_2,
  input  logic [15:0]        range_0,
  input  logic [15:0]        range_1,
  input  logic [15:0]        range_2,
  input  logic [15:0]        iter_cnt,
  db_read_addr_gen_if.master rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] idx0_q, idx0_d;
  logic [15:0] idx1_q, idx1_d;
  logic [15:0] idx2_q, idx2_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic        bank_sel_q, bank_sel_d;

  logic [1:0]  dim_eff;
  logic [15:0] max0, max1, max2, last_pass;
  logic        last0, last1, last2;
  logic        xfer, pass_end, run_end;

  always_comb begin
    if (dimensionality == 4'd0)     dim_eff = 2'd1;
    else if (dimensionality > 4'd3) dim_eff = 2'd3;
    else                            dim_eff = dimensionality[1:0];
  end

  // Inactive dimensions and zero trip counts both collapse to a single iteration.
  assign max0      = (range_0 == 16'd0) ? 16'd0 : range_0 - 16'd1;
  assign max1      = (dim_eff < 2'd2 || range_1 == 16'd0) ? 16'd0 : range_1 - 16'd1;
  assign max2      = (dim_eff != 2'd3 || range_2 == 16'd0) ? 16'd0 : range_2 - 16'd1;
  assign last_pass = (iter_cnt == 16'd0) ? 16'd0 : iter_cnt - 16'd1;

  assign last0 = (idx0_q == max0);
  assign last1 = (idx1_q == max1);
  assign last2 = (idx2_q == max2);

  // An aborting flush or reset discards the handshake in the same cycle.
  assign xfer     = (state_q == RUN) && rd.addr_ready && clk_en && !flush && !reset;
  assign pass_end = xfer && last0 && last1 && last2;
  assign run_end  = pass_end && (pass_cnt_q == last_pass);

  always_comb begin
    // NOTE: every _d gets a hold default up front so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    idx0_d     = idx0_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    pass_cnt_d = pass_cnt_q;
    bank_sel_d = bank_sel_q;

    if (clk_en) begin
      if (flush) begin
        state_d    = IDLE;
        idx0_d     = 16'd0;
        idx1_d     = 16'd0;
        idx2_d     = 16'd0;
        pass_cnt_d = 16'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_d    = RUN;
              idx0_d     = 16'd0;
              idx1_d     = 16'd0;
              idx2_d     = 16'd0;
              pass_cnt_d = 16'd0;
            end
          end
          RUN: begin
            if (xfer) begin
              if (last0) begin
                idx0_d = 16'd0;
                if (last1) begin
                  idx1_d = 16'd0;
                  idx2_d = last2 ? 16'd0 : idx2_q + 16'd1;
                end else begin
                  idx1_d = idx1_q + 16'd1;
                end
              end else begin
                idx0_d = idx0_q + 16'd1;
              end
              if (pass_end) begin
                bank_sel_d = ~bank_sel_q;
                pass_cnt_d = pass_cnt_q + 16'd1;
                if (run_end) state_d = DONE;
              end
            end
          end
          DONE: begin
            state_d    = IDLE;
            idx0_d     = 16'd0;
            idx1_d     = 16'd0;
            idx2_d     = 16'd0;
            pass_cnt_d = 16'd0;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx0_q     <= 16'd0;
      idx1_q     <= 16'd0;
      idx2_q     <= 16'd0;
      pass_cnt_q <= 16'd0;
      bank_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx0_q     <= idx0_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      pass_cnt_q <= pass_cnt_d;
      bank_sel_q <= bank_sel_d;
    end
  end

  assign rd.addr_out   = starting_addr + idx0_q * stride_0 + idx1_q * stride_1 + idx2_q * stride_2;
  assign rd.addr_valid = (state_q == RUN) && !reset;
  assign rd.bank_sel   = bank_sel_q;
  assign rd.pass_done  = pass_end;
  assign rd.done       = (state_q == DONE) && clk_en && !flush && !reset;

endmodule

// File: tb/tb_db_read_addr_gen.sv
// Bench for db_read_addr_gen: table of loop configurations plus stall, reset, flush
// and clock-enable sequences; a negedge monitor scores every transfer against a queue.
module tb_db_read_addr_gen;

  typedef struct {
    logic [3:0]  dim;
    logic [15:0] start_addr;
    logic [15:0] s0, s1, s2;
    logic [15:0] r0, r1, r2;
    logic [15:0] iter;
    int          exp_xfers;
    int          exp_passes;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  dimensionality = 4'd1;
  logic [15:0] starting_addr = 16'h0;
  logic [15:0] stride_0 = 16'h0, stride_1 = 16'h0, stride_2 = 16'h0;
  logic [15:0] range_0 = 16'h0, range_1 = 16'h0, range_2 = 16'h0;
  logic [15:0] iter_cnt = 16'h0;

  db_read_addr_gen_if rd();

  db_read_addr_gen dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .flush          (flush),
    .start          (start),
    .dimensionality (dimensionality),
    .starting_addr  (starting_addr),
    .stride_0       (stride_0),
    .stride_1       (stride_1),
    .stride_2       (stride_2),
    .range_0        (range_0),
    .range_1        (range_1),
    .range_2        (range_2),
    .iter_cnt       (iter_cnt),
    .rd             (rd)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   done_cnt, xfer_cnt, first_xfer_cyc, last_xfer_cyc, last_pass_cyc, done_cyc;
  logic exp_bank;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted address pops one expected entry.
  always @(negedge clk) begin
    if (mon_en && !reset && !flush) begin
      if (clk_en && rd.addr_valid === 1'b1 && rd.addr_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_xfer: got addr %0h want no transfer (cycle %0d)", rd.addr_out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("addr", 32'(rd.addr_out), 32'(mon_e.addr));
          check("pass_done", 32'(rd.pass_done), 32'(mon_e.last));
        end
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end else begin
        check("pass_done_quiet", 32'(rd.pass_done), 32'd0);
      end
      if (rd.pass_done === 1'b1) last_pass_cyc = cyc;
      if (!clk_en) check("done_frozen", 32'(rd.done), 32'd0);
      if (rd.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_cfg(input vec_t v);
    dimensionality = v.dim;
    starting_addr  = v.start_addr;
    stride_0 = v.s0;
    stride_1 = v.s1;
    stride_2 = v.s2;
    range_0  = v.r0;
    range_1  = v.r1;
    range_2  = v.r2;
    iter_cnt = v.iter;
  endtask

  // Reference model: plain nested loops over the clamped configuration.
  task automatic push_model(input vec_t v);
    int d, n0, n1, n2, it;
    logic [15:0] a;
    d  = (v.dim == 4'd0) ? 1 : (v.dim > 4'd3) ? 3 : int'(v.dim);
    n0 = (v.r0 == 16'd0) ? 1 : int'(v.r0);
    n1 = (d < 2 || v.r1 == 16'd0) ? 1 : int'(v.r1);
    n2 = (d < 3 || v.r2 == 16'd0) ? 1 : int'(v.r2);
    it = (v.iter == 16'd0) ? 1 : int'(v.iter);
    for (int p = 0; p < it; p++)
      for (int k = 0; k < n2; k++)
        for (int j = 0; j < n1; j++)
          for (int i = 0; i < n0; i++) begin
            a = v.start_addr + 16'(i) * v.s0 + 16'(j) * v.s1 + 16'(k) * v.s2;
            exp_q.push_back('{addr: a, last: (i == n0 - 1 && j == n1 - 1 && k == n2 - 1)});
          end
  endtask

  task automatic clr_mon();
    done_cnt       = 0;
    xfer_cnt       = 0;
    first_xfer_cyc = -1;
    last_xfer_cyc  = -1;
    last_pass_cyc  = -1;
    done_cyc       = -1;
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    sc    = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit inject);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      start = inject && (n == 2);
      step(1);
      n++;
    end
    start = 1'b0;
    check({name, "_timeout"}, 32'(done_cnt != 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   sc;

    vecs[0] = '{dim: 4'd3, start_addr: 16'h0000, s0: 16'd1, s1: 16'd3, s2: 16'd9,
                r0: 16'd3, r1: 16'd3, r2: 16'd3, iter: 16'd1, exp_xfers: 27, exp_passes: 1};
    vecs[1] = '{dim: 4'd1, start_addr: 16'd5, s0: 16'd2, s1: 16'd7, s2: 16'd7,
                r0: 16'd4, r1: 16'd5, r2: 16'd5, iter: 16'd2, exp_xfers: 8, exp_passes: 2};
    vecs[2] = '{dim: 4'd2, start_addr: 16'h0000, s0: 16'hFFFF, s1: 16'd1, s2: 16'd7,
                r0: 16'd2, r1: 16'd2, r2: 16'd0, iter: 16'd1, exp_xfers: 4, exp_passes: 1};
    vecs[3] = '{dim: 4'd0, start_addr: 16'h0100, s0: 16'd5, s1: 16'd5, s2: 16'd5,
                r0: 16'd0, r1: 16'd3, r2: 16'd3, iter: 16'd0, exp_xfers: 1, exp_passes: 1};
    vecs[4] = '{dim: 4'd7, start_addr: 16'hF000, s0: 16'h0010, s1: 16'h0100, s2: 16'h1000,
                r0: 16'd2, r1: 16'd0, r2: 16'd2, iter: 16'd3, exp_xfers: 12, exp_passes: 3};

    rd.addr_ready = 1'b1;
    starting_addr = 16'h1234;
    clr_mon();

    reset = 1'b1;
    step(2);
    check("rst_valid", 32'(rd.addr_valid), 32'd0);
    check("rst_bank", 32'(rd.bank_sel), 32'd0);
    check("rst_pass_done", 32'(rd.pass_done), 32'd0);
    check("rst_done", 32'(rd.done), 32'd0);
    check("rst_addr", 32'(rd.addr_out), 32'h1234);
    reset = 1'b0;
    mon_en = 1'b1;
    step(1);
    check("idle_valid", 32'(rd.addr_valid), 32'd0);
    exp_bank = 1'b0;

    for (int t = 0; t < 5; t++) begin
      apply_cfg(vecs[t]);
      clr_mon();
      step(1);
      check($sformatf("c%0d_idle_addr", t), 32'(rd.addr_out), 32'(vecs[t].start_addr));
      check($sformatf("c%0d_idle_valid", t), 32'(rd.addr_valid), 32'd0);
      push_model(vecs[t]);
      pulse_start(sc);
      wait_done($sformatf("c%0d", t), 400, vecs[t].exp_xfers >= 4);
      step(2);
      check($sformatf("c%0d_xfers", t), 32'(xfer_cnt), 32'(vecs[t].exp_xfers));
      check($sformatf("c%0d_first_lat", t), 32'(first_xfer_cyc), 32'(sc + 1));
      check($sformatf("c%0d_back_to_back", t), 32'(last_xfer_cyc - first_xfer_cyc), 32'(vecs[t].exp_xfers - 1));
      check($sformatf("c%0d_done_after_pass", t), 32'(done_cyc), 32'(last_pass_cyc + 1));
      check($sformatf("c%0d_done_cnt", t), 32'(done_cnt), 32'd1);
      check($sformatf("c%0d_q_empty", t), 32'(exp_q.size()), 32'd0);
      check($sformatf("c%0d_end_valid", t), 32'(rd.addr_valid), 32'd0);
      exp_bank = exp_bank ^ vecs[t].exp_passes[0];
      check($sformatf("c%0d_bank", t), 32'(rd.bank_sel), 32'(exp_bank));
    end

    // Backpressure: ready low for three cycles after addresses 0,1,2.
    apply_cfg(vecs[0]);
    clr_mon();
    step(1);
    push_model(vecs[0]);
    pulse_start(sc);
    step(3);
    rd.addr_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step(0);
      #1;
      check("stall_addr", 32'(rd.addr_out), 32'd3);
      check("stall_valid", 32'(rd.addr_valid), 32'd1);
      step(1);
    end
    rd.addr_ready = 1'b1;
    wait_done("stall", 400, 1'b0);
    step(2);
    check("stall_xfers", 32'(xfer_cnt), 32'd27);
    check("stall_span", 32'(last_xfer_cyc - first_xfer_cyc), 32'd29);
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);
    check("stall_done_cnt", 32'(done_cnt), 32'd1);
    exp_bank = ~exp_bank;
    check("stall_bank", 32'(rd.bank_sel), 32'(exp_bank));

    // Reset after ten transfers, then a clean rerun.
    clr_mon();
    push_model(vecs[0]);
    pulse_start(sc);
    step(10);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.delete();
    exp_bank = 1'b0;
    check("mrst_bank", 32'(rd.bank_sel), 32'd0);
    check("mrst_valid", 32'(rd.addr_valid), 32'd0);
    check("mrst_addr", 32'(rd.addr_out), 32'd0);
    step(3);
    check("mrst_no_done", 32'(done_cnt), 32'd0);
    check("mrst_xfers", 32'(xfer_cnt), 32'd10);
    clr_mon();
    push_model(vecs[0]);
    pulse_start(sc);
    wait_done("mrst_rerun", 400, 1'b0);
    step(2);
    check("mrst_rerun_xfers", 32'(xfer_cnt), 32'd27);
    check("mrst_rerun_first", 32'(first_xfer_cyc), 32'(sc + 1));
    check("mrst_rerun_q_empty", 32'(exp_q.size()), 32'd0);
    exp_bank = ~exp_bank;
    check("mrst_rerun_bank", 32'(rd.bank_sel), 32'(exp_bank));

    // Flush after five transfers: back to IDLE, bank untouched, no pulses.
    clr_mon();
    push_model(vecs[0]);
    pulse_start(sc);
    step(5);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    exp_q.delete();
    check("flush_valid", 32'(rd.addr_valid), 32'd0);
    check("flush_bank", 32'(rd.bank_sel), 32'(exp_bank));
    check("flush_addr", 32'(rd.addr_out), 32'd0);
    step(3);
    check("flush_no_done", 32'(done_cnt), 32'd0);
    check("flush_no_pass", 32'(last_pass_cyc < 0), 32'd1);
    check("flush_xfers", 32'(xfer_cnt), 32'd5);

    // Clock-enable freeze for four cycles mid-run.
    clr_mon();
    push_model(vecs[0]);
    pulse_start(sc);
    step(7);
    clk_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check("frz_addr", 32'(rd.addr_out), 32'd7);
      check("frz_valid", 32'(rd.addr_valid), 32'd1);
      check("frz_bank", 32'(rd.bank_sel), 32'(exp_bank));
      step(1);
    end
    clk_en = 1'b1;
    wait_done("frz", 400, 1'b0);
    step(2);
    check("frz_xfers", 32'(xfer_cnt), 32'd27);
    check("frz_span", 32'(last_xfer_cyc - first_xfer_cyc), 32'd30);
    check("frz_q_empty", 32'(exp_q.size()), 32'd0);
    check("frz_done_cnt", 32'(done_cnt), 32'd1);
    exp_bank = ~exp_bank;
    check("frz_bank_end", 32'(rd.bank_sel), 32'(exp_bank));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
